issue_scheduler: RTL and testbench
==================================

# issue_scheduler

Issue controller between the instruction fetcher and the out-of-order back end. It buffers fetched instructions in a circular queue and presents the head entry to the `dispatcher` decoder, driving its `inst_flag`/`inst` inputs. It reads back the decoded `inst_type` and issues the head, at most one instruction per cycle, to the ROB plus exactly one of RS or LSB. It issues only when every target has space, and clears the queue on a pipeline flush.

## Interface
- DEPTH, 16, queue entries; power of two, ≥2
- PTR_W, 4, log2(DEPTH)
- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global enable; low freezes all state
- if_valid  input  1  fetcher presents an instruction this cycle
- if_inst  input  32  fetched instruction
- if_pc  input  32  PC of if_inst
- iq_full  output  1  queue cannot accept; combinational from state
- flush_in  input  1  mispredict/clear request
- dec_flag  output  1  to dispatcher inst_flag; high when head valid
- dec_inst  output  32  to dispatcher inst; head instruction
- dec_type  input  3  dispatcher inst_type (`ALU/`JMP/`LD/`ST/`BRC)
- rob_full, rs_full, lsb_full  input  1 each  downstream occupancy
- issue_rob, issue_rs, issue_lsb  output  1 each  registered one-cycle issue strobes
- issue_inst  output  32  registered issued instruction
- issue_pc  output  32  registered issued PC
- stat_stall, stat_issued  output  32 each  counters (see Configuration)

## Operation
- Storage: inst/pc arrays DEPTH deep; head, tail (PTR_W, wrap modulo DEPTH); count (PTR_W+1 bits, 0..DEPTH).
- Push: if_valid && !iq_full && state≠FLUSH writes to tail, tail+1. if_valid while iq_full is dropped (fetcher must hold).
- iq_full = (count==DEPTH) || state==FLUSH. No same-cycle bypass when full, even if pop occurs.
- dec_flag = count≠0 && state≠FLUSH; dec_inst = inst[head].
- Routing: `ALU/`JMP/`BRC → RS; `LD/`ST → LSB; every instruction → ROB.
- Issue condition: dec_flag && !rob_full && !(target full). On issue: head+1, count−1, next edge issue_rob=1, issue_rs or issue_lsb=1, and issue_inst/issue_pc latch the head.
- Push+pop same cycle: count unchanged, both pointers advance.
- FSM (registered): EMPTY (count==0), READY (head issuable), WAIT (head blocked by full), FLUSH.
  - EMPTY→READY/WAIT on push; READY↔WAIT by issue condition; any→EMPTY when count reaches 0.
  - flush_in in any state → FLUSH: head=tail=0, count=0, issue strobes 0 next edge; FLUSH always → EMPTY after one cycle.
- flush_in wins over simultaneous push and issue; neither takes effect.
- rdy_in low: no push, no issue, strobes 0, FSM/pointers hold; flush_in ignored.

## Timing
- Reset (rst_in low, async): head=tail=count=0, state=EMPTY, all issue_* =0, issue_inst/issue_pc=0, counters=0, iq_full=0, dec_flag=0.
- Enqueue at edge t → dec_flag at t+1 → issue strobe at edge t+2 at earliest (2-cycle latency).
- Steady state throughput: 1 issue/cycle.
- Issue strobes are single-cycle pulses; downstream samples them at the following edge.
- Full→drain: first issue at cycle c clears iq_full in cycle c+1.
- Reset asserted mid-operation discards queue contents immediately.

## Configuration
- ISSUE_STAT_EN defined: stat_stall increments each cycle with rdy_in && dec_flag && no issue; stat_issued increments per issue; both wrap at 2^32, cleared by reset only (not by flush).
- Undefined: both counter outputs tied to 0, no counter flops.

## Test plan
- Reset then push one ADDI (0x00100093, pc 0x0) with all fulls low → issue_rob=issue_rs=1 two edges after push, issue_pc=0x0.
- Push LW (0x0000A103) with lsb_full=1 for 5 cycles → no strobes, state WAIT, stat_stall=5 (ISSUE_STAT_EN); release → issue_lsb pulse next edge.
- Push 16 entries with rob_full=1 → iq_full=1, 17th if_valid dropped; release → 16 in-order issues, pc 0x0..0x3C, one per cycle.
- Push/pop simultaneously for 40 cycles → count constant, pointers wrap, issue order matches push order.
- 8 entries queued, flush_in together with if_valid → queue empty, no strobe next edge, iq_full high for one cycle, pushed instruction never issued.
- rdy_in low 3 cycles with head ready → no strobes, state held; rdy_in high → issue next edge.

Source files
------------

// File: rtl/issue_scheduler.sv
// Issue queue between fetch and the out-of-order back end: buffers fetched instructions and
// issues the head to ROB plus RS or LSB. Define ISSUE_STAT_EN to build the stall/issue counters.
module issue_scheduler #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        iq_full,
  input  logic        flush_in,
  output logic        dec_flag,
  output logic [31:0] dec_inst,
  input  logic [2:0]  dec_type,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  output logic        issue_rob,
  output logic        issue_rs,
  output logic        issue_lsb,
  output logic [31:0] issue_inst,
  output logic [31:0] issue_pc,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_issued
);

  // Dispatcher type codes that route to the LSB; every other code goes to the RS.
  localparam logic [2:0] TypeLd = 3'd2;
  localparam logic [2:0] TypeSt = 3'd3;

  localparam logic [PTR_W:0] CountMax = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {StEmpty, StReady, StWait, StFlush} state_e;

  logic [31:0]    r_inst_mem [DEPTH];
  logic [31:0]    r_pc_mem   [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0] r_count;
  state_e         r_state;
  logic           r_issue_rob, r_issue_rs, r_issue_lsb;
  logic [31:0]    r_issue_inst, r_issue_pc;

  logic           w_full, w_dec_flag, w_to_lsb, w_target_full;
  logic           w_issue, w_push;
  logic [PTR_W:0] w_count_next;
  state_e         w_state_next;

  assign w_full        = (r_count == CountMax) || (r_state == StFlush);
  assign w_dec_flag    = (r_count != '0) && (r_state != StFlush);
  assign w_to_lsb      = (dec_type == TypeLd) || (dec_type == TypeSt);
  assign w_target_full = w_to_lsb ? lsb_full : rs_full;
  assign w_issue       = rdy_in && !flush_in && w_dec_flag && !rob_full && !w_target_full;
  assign w_push        = rdy_in && !flush_in && if_valid && !w_full;

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_issue})
      2'b10:   w_count_next = r_count + (PTR_W+1)'(1);
      2'b01:   w_count_next = r_count - (PTR_W+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // WAIT marks a head that was presented but blocked by a full target this cycle.
  always_comb begin
    w_state_next = StReady;
    if (w_count_next == '0) begin
      w_state_next = StEmpty;
    end else if (w_dec_flag && !w_issue) begin
      w_state_next = StWait;
    end
  end

  // Storage has no reset; head/tail/count decide what is valid.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_inst_mem[r_tail] <= if_inst;
      r_pc_mem[r_tail]   <= if_pc;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= StEmpty;
      r_issue_rob  <= 1'b0;
      r_issue_rs   <= 1'b0;
      r_issue_lsb  <= 1'b0;
      r_issue_inst <= '0;
      r_issue_pc   <= '0;
    end else begin
      r_issue_rob <= 1'b0;
      r_issue_rs  <= 1'b0;
      r_issue_lsb <= 1'b0;
      if (rdy_in) begin
        if (flush_in) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
          r_state <= StFlush;
        end else begin
          if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
          end
          if (w_issue) begin
            r_head       <= r_head + PTR_W'(1);
            r_issue_rob  <= 1'b1;
            r_issue_rs   <= !w_to_lsb;
            r_issue_lsb  <= w_to_lsb;
            r_issue_inst <= r_inst_mem[r_head];
            r_issue_pc   <= r_pc_mem[r_head];
          end
          r_count <= w_count_next;
          r_state <= w_state_next;
        end
      end
    end
  end

`ifdef ISSUE_STAT_EN
  logic [31:0] r_stat_stall, r_stat_issued;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_stat_stall  <= '0;
      r_stat_issued <= '0;
    end else begin
      if (rdy_in && w_dec_flag && !w_issue) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
      if (w_issue) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
    end
  end

  assign stat_stall  = r_stat_stall;
  assign stat_issued = r_stat_issued;
`else
  assign stat_stall  = '0;
  assign stat_issued = '0;
`endif

  assign iq_full     = w_full;
  assign dec_flag    = w_dec_flag;
  assign dec_inst    = r_inst_mem[r_head];
  assign issue_rob   = r_issue_rob;
  assign issue_rs    = r_issue_rs;
  assign issue_lsb   = r_issue_lsb;
  assign issue_inst  = r_issue_inst;
  assign issue_pc    = r_issue_pc;

endmodule

// File: tb/tb_issue_scheduler.sv
// Randomized bench for issue_scheduler against a queue-based reference model, with a dispatcher
// stand-in that decodes the presented head instruction into a type code.
module tb_issue_scheduler;

  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        flush_in = 1'b0;
  logic        rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
  logic        iq_full, dec_flag;
  logic [31:0] dec_inst;
  logic [2:0]  dec_type;
  logic        issue_rob, issue_rs, issue_lsb;
  logic [31:0] issue_inst, issue_pc, stat_stall, stat_issued;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [63:0] mq[$];
  bit          m_flushing;
  logic        m_rob, m_rs, m_lsb;
  logic [31:0] m_inst, m_pc, m_stall, m_issued, pc_ctr;

  issue_scheduler #(.DEPTH(16), .PTR_W(4)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .iq_full     (iq_full),
    .flush_in    (flush_in),
    .dec_flag    (dec_flag),
    .dec_inst    (dec_inst),
    .dec_type    (dec_type),
    .rob_full    (rob_full),
    .rs_full     (rs_full),
    .lsb_full    (lsb_full),
    .issue_rob   (issue_rob),
    .issue_rs    (issue_rs),
    .issue_lsb   (issue_lsb),
    .issue_inst  (issue_inst),
    .issue_pc    (issue_pc),
    .stat_stall  (stat_stall),
    .stat_issued (stat_issued)
  );

  always #5 clk_in = ~clk_in;

  // Dispatcher stand-in: ALU=0 JMP=1 LD=2 ST=3 BRC=4
  function automatic logic [2:0] decode_type(input logic [31:0] inst);
    case (inst[6:0])
      7'b0000011:             return 3'd2;
      7'b0100011:             return 3'd3;
      7'b1100011:             return 3'd4;
      7'b1101111, 7'b1100111: return 3'd1;
      default:                return 3'd0;
    endcase
  endfunction

  assign dec_type = decode_type(dec_inst);

  function automatic bit is_mem(input logic [31:0] inst);
    return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[6];
    logic [31:0] r;
    ops = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 5)]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs();
    check_eq("issue_rob", issue_rob, m_rob);
    check_eq("issue_rs", issue_rs, m_rs);
    check_eq("issue_lsb", issue_lsb, m_lsb);
    check_eq("issue_inst", issue_inst, m_inst);
    check_eq("issue_pc", issue_pc, m_pc);
`ifdef ISSUE_STAT_EN
    check_eq("stat_stall", stat_stall, m_stall);
    check_eq("stat_issued", stat_issued, m_issued);
`else
    check_eq("stat_stall", stat_stall, 0);
    check_eq("stat_issued", stat_issued, 0);
`endif
  endtask

  // One clock: drive inputs, check combinational view at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [31:0] inst, input logic fl, input logic rdy,
                      input logic rf, input logic sf, input logic lf);
    bit full, flag, lsb, iss, psh;
    logic [63:0] hd;
    if_valid = v; if_inst = inst; if_pc = pc_ctr; flush_in = fl; rdy_in = rdy;
    rob_full = rf; rs_full = sf; lsb_full = lf;
    @(negedge clk_in);
    full = (mq.size() == DEPTH) || m_flushing;
    flag = (mq.size() != 0) && !m_flushing;
    hd   = flag ? mq[0] : 64'd0;
    check_eq("iq_full", iq_full, full);
    check_eq("dec_flag", dec_flag, flag);
    if (flag) check_eq("dec_inst", dec_inst, hd[63:32]);
    lsb = is_mem(hd[63:32]);
    iss = rdy && !fl && flag && !rf && !(lsb ? lf : sf);
    psh = rdy && !fl && v && !full;
    @(posedge clk_in);
    m_rob = 1'b0; m_rs = 1'b0; m_lsb = 1'b0;
    if (rdy) begin
      if (fl) begin
        mq.delete();
        m_flushing = 1'b1;
      end else begin
        m_flushing = 1'b0;
        if (iss) begin
          void'(mq.pop_front());
          m_rob = 1'b1; m_rs = !lsb; m_lsb = lsb;
          m_inst = hd[63:32]; m_pc = hd[31:0];
        end
        if (psh) begin
          mq.push_back({inst, pc_ctr});
          pc_ctr += 32'd4;
        end
      end
    end
    if (rdy && flag && !iss) m_stall++;
    if (iss) m_issued++;
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #2;
    mq.delete();
    m_flushing = 1'b0;
    m_rob = 1'b0; m_rs = 1'b0; m_lsb = 1'b0;
    m_inst = '0; m_pc = '0; m_stall = '0; m_issued = '0; pc_ctr = '0;
    check_eq("rst_iq_full", iq_full, 0);
    check_eq("rst_dec_flag", dec_flag, 0);
    check_regs();
    rst_in = 1'b1;
    #1;
  endtask

  initial begin
    int pf, pfl;
    #1;
    do_reset();
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // Single ADDI, all targets free
    step(1'b1, 32'h00100093, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // LW blocked by LSB for 5 cycles, then released
    step(1'b1, 32'h0000A103, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Fill to full behind a full ROB, try a 17th push, then drain
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(18);

    // Simultaneous push/pop
    for (int i = 0; i < 4; i++) step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Flush with 8 queued and a concurrent push
    for (int i = 0; i < 8; i++) step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_inst(), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // rdy_in low with a ready head, including an ignored flush
    step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_inst(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, rand_inst(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized segments with varying back-pressure and flush rates
    for (int seg = 0; seg < 8; seg++) begin
      pf  = 10 + seg * 10;
      pfl = (seg % 3 == 0) ? 0 : 3;
      if (seg == 5) do_reset();
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 99) < 75, rand_inst(), $urandom_range(0, 99) < pfl,
             $urandom_range(0, 99) < 90, $urandom_range(0, 99) < pf,
             $urandom_range(0, 99) < pf, $urandom_range(0, 99) < pf);
      end
    end

    // Reset in the middle of a busy queue
    for (int i = 0; i < 6; i++) step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
